load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sizes, extends and optionally splits CPU memory accesses.
// Misaligned accesses become byte sequences or errors depending on SPLIT_MISALIGNED.
module load_store_unit #(
    parameter int WORD_SIZE        = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 mem_write_en,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_write_data,
    output logic [2:0]           mem_ctrl,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state_q;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] acc_q;
    logic [1:0]           cnt_q;
    logic [1:0]           last_q;
    logic                 split_q;
    logic                 ready_q;
    logic                 rvalid_q;
    logic                 rerr_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 mwe_q;
    logic [WORD_SIZE-1:0] maddr_q;
    logic [WORD_SIZE-1:0] mwdata_q;
    logic [2:0]           mctrl_q;

    logic                 hs_illegal;
    logic                 hs_mis;
    logic                 hs_err;
    logic [1:0]           hs_size_m1;
    logic [1:0]           cnt_d;
    logic [7:0]           nxt_byte;
    logic [WORD_SIZE-1:0] cap;
    logic [WORD_SIZE-1:0] ext;

    assign req_ready      = ready_q;
    assign resp_valid     = rvalid_q;
    assign resp_err       = rerr_q;
    assign resp_rdata     = rdata_q;
    assign mem_write_en   = mwe_q;
    assign mem_addr       = maddr_q;
    assign mem_write_data = mwdata_q;
    assign mem_ctrl       = mctrl_q;

    // Request decode, evaluated on the raw inputs at handshake time
    always_comb begin
        hs_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                     (req_funct3 == 3'd7) || (req_we && req_funct3[2]);
        hs_size_m1 = 2'd0;
        hs_mis     = 1'b0;
        if (req_funct3[1:0] == 2'd1) begin
            hs_size_m1 = 2'd1;
            hs_mis     = req_addr[0];
        end else if (req_funct3[1:0] == 2'd2) begin
            hs_size_m1 = 2'd3;
            hs_mis     = |req_addr[1:0];
        end
        hs_err = hs_illegal || (hs_mis && !SPLIT_MISALIGNED);
    end

    assign cnt_d    = cnt_q + 2'd1;
    assign nxt_byte = 8'(wdata_q >> {cnt_d, 3'b000});

    // Load data captured this cycle, merged with earlier split bytes
    always_comb begin
        cap = acc_q;
        if (split_q) begin
            cap = acc_q | (WORD_SIZE'(mem_rdata[7:0]) << {cnt_q, 3'b000});
        end else begin
            unique case (f3_q[1:0])
                2'd0:    cap = WORD_SIZE'(mem_rdata[7:0]);
                2'd1:    cap = WORD_SIZE'(mem_rdata[15:0]);
                default: cap = mem_rdata;
            endcase
        end
    end

    always_comb begin
        unique case (f3_q)
            3'd0:    ext = {{(WORD_SIZE-8){cap[7]}}, cap[7:0]};
            3'd1:    ext = {{(WORD_SIZE-16){cap[15]}}, cap[15:0]};
            3'd4:    ext = WORD_SIZE'(cap[7:0]);
            3'd5:    ext = WORD_SIZE'(cap[15:0]);
            default: ext = cap;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
            split_q  <= 1'b0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mctrl_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        if (hs_err) begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            rerr_q   <= 1'b1;
                            rdata_q  <= '0;
                        end else begin
                            state_q  <= ACCESS;
                            split_q  <= hs_mis;
                            last_q   <= hs_mis ? hs_size_m1 : 2'd0;
                            mwe_q    <= req_we;
                            maddr_q  <= req_addr;
                            mctrl_q  <= hs_mis ? 3'd0 : {1'b0, req_funct3[1:0]};
                            mwdata_q <= hs_mis ? WORD_SIZE'(req_wdata[7:0])
                                               : req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    acc_q <= cap;
                    if (cnt_q == last_q) begin
                        state_q  <= RESP;
                        mwe_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        rerr_q   <= 1'b0;
                        rdata_q  <= we_q ? '0 : ext;
                    end else begin
                        cnt_q    <= cnt_d;
                        maddr_q  <= addr_q + WORD_SIZE'(cnt_d);
                        mwdata_q <= WORD_SIZE'(nxt_byte);
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                    rerr_q   <= 1'b0;
                    rdata_q  <= '0;
                    ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model.
// Second instance exercises the non-splitting (error) configuration.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_rdata;
    logic [2:0]  mem_ctrl;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;
    logic        b_mem_write_en;
    logic [31:0] b_mem_addr, b_mem_write_data;
    logic [2:0]  b_mem_ctrl;
    logic [31:0] b_mem_rdata;

    logic [7:0]  mem      [0:255];
    logic [7:0]  init_mem [0:255];
    logic [7:0]  ref_mem  [0:255];
    logic        preload;
    int          total = 0;
    int          bad = 0;
    int          b_we_cnt = 0;

    load_store_unit #(.WORD_SIZE(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_ctrl(mem_ctrl),
        .mem_rdata(mem_rdata)
    );

    load_store_unit #(.WORD_SIZE(32), .SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err),
        .mem_write_en(b_mem_write_en), .mem_addr(b_mem_addr),
        .mem_write_data(b_mem_write_data), .mem_ctrl(b_mem_ctrl),
        .mem_rdata(b_mem_rdata)
    );

    assign b_mem_rdata = 32'h12345678;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench memory: 256 bytes, little-endian, wraps on the low address byte
    always_comb begin
        mem_rdata = {mem[8'(mem_addr[7:0] + 8'd3)], mem[8'(mem_addr[7:0] + 8'd2)],
                     mem[8'(mem_addr[7:0] + 8'd1)], mem[mem_addr[7:0]]};
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        end else if (mem_write_en) begin
            for (int i = 0; i < (1 << mem_ctrl); i++)
                mem[8'(mem_addr[7:0] + 8'(i))] <= mem_write_data[8*i +: 8];
        end
        if (b_mem_write_en) b_we_cnt <= b_we_cnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One request on the main instance; model computes every cycle's outputs
    task automatic do_req(input bit we, input bit [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got);
        int          sz, lat, k;
        bit          err, mis;
        logic [63:0] v;
        logic [31:0] ea;
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]);
        mis = (a % sz) != 0;
        lat = err ? 1 : (mis ? sz + 1 : 2);
        v   = 0;
        if (!we && !err) begin
            for (int j = 0; j < sz; j++)
                v |= 64'(ref_mem[8'(a + 32'(j))]) << (8 * j);
            if (f3 < 3'd4 && sz < 4 && v[8*sz-1])
                v |= ~((64'd1 << (8 * sz)) - 64'd1);
        end
        got = 'x;
        @(negedge clk);
        chk("ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'($urandom); req_we = 1'($urandom);
        req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= lat; c++) begin
            if (c < lat) begin
                k  = mis ? c - 1 : 0;
                ea = mis ? a + 32'(k) : a;
                chk("busy_ready", 64'(req_ready), 64'd0);
                chk("no_resp", 64'(resp_valid), 64'd0);
                chk("mem_we", 64'(mem_write_en), 64'(we));
                chk("mem_addr", 64'(mem_addr), 64'(ea));
                chk("mem_ctrl", 64'(mem_ctrl), mis ? 64'd0 : 64'(f3[1:0]));
                if (we && mis)
                    chk("wbyte", 64'(mem_write_data[7:0]), 64'((wd >> (8*k)) & 32'hFF));
                else if (we)
                    chk("wword", 64'(mem_write_data), 64'(wd));
            end else begin
                chk("resp_valid", 64'(resp_valid), 64'd1);
                chk("resp_err", 64'(resp_err), 64'(err));
                chk("resp_rdata", 64'(resp_rdata), 64'(v[31:0]));
                chk("resp_we0", 64'(mem_write_en), 64'd0);
                got = resp_rdata;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("resp_pulse", 64'(resp_valid), 64'd0);
        chk("ready_back", 64'(req_ready), 64'd1);
        if (we && !err)
            for (int j = 0; j < sz; j++) ref_mem[8'(a + 32'(j))] = wd[8*j +: 8];
    endtask

    logic [31:0] got;
    logic [31:0] ra;
    int          diff;

    initial begin
        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = '0;
        b_req_addr = '0; b_req_wdata = '0;
        for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
        for (int i = 8'h80; i < 8'h90; i++) init_mem[i] = 8'h00;
        init_mem[0] = 8'h03; init_mem[1] = 8'hA3;
        init_mem[2] = 8'h44; init_mem[3] = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_mem[i];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_we", 64'(mem_write_en), 64'd0);
        @(negedge clk);
        rst = 1'b0; preload = 1'b0;

        do_req(1'b0, 3'd2, 32'h0, 32'h0, got);
        chk("lw0_lit", 64'(got), 64'h0044A303);
        do_req(1'b0, 3'd0, 32'h1, 32'h0, got);
        chk("lb1_lit", 64'(got), 64'hFFFFFFA3);
        do_req(1'b0, 3'd4, 32'h1, 32'h0, got);
        chk("lbu1_lit", 64'(got), 64'h000000A3);
        do_req(1'b0, 3'd1, 32'h1, 32'h0, got);
        chk("lh1_lit", 64'(got), 64'h000044A3);
        do_req(1'b1, 3'd2, 32'h82, 32'hDEADBEEF, got);
        do_req(1'b0, 3'd2, 32'h84, 32'h0, got);
        chk("lw84_lit", 64'(got), 64'h0000DEAD);
        do_req(1'b0, 3'd3, 32'h0, 32'h0, got);
        do_req(1'b1, 3'd4, 32'h10, 32'h0, got);

        for (int n = 0; n < 400; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                             : 32'($urandom_range(0, 255));
            do_req(1'($urandom), 3'($urandom_range(0, 7)), ra, $urandom, got);
        end

        // Reset in the middle of a split store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h91; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ab_we0", 64'(mem_write_en), 64'd1);
        chk("ab_byte0", 64'(mem_write_data[7:0]), 64'hEF);
        @(posedge clk); #1;
        chk("ab_we1", 64'(mem_write_en), 64'd1);
        chk("ab_addr1", 64'(mem_addr), 64'h92);
        rst = 1'b1;
        #1;
        chk("ab_we_drop", 64'(mem_write_en), 64'd0);
        chk("ab_ready", 64'(req_ready), 64'd1);
        chk("ab_novalid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_mem[8'h91] = 8'hEF;
        repeat (5) begin
            @(posedge clk); #1;
            chk("ab_quiet", 64'(resp_valid), 64'd0);
        end
        do_req(1'b0, 3'd2, 32'h90, 32'h0, got);

        // Non-splitting instance
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_funct3 = 3'd1;
        b_req_addr = 32'h3; b_req_wdata = 32'hCAFE;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        chk("ns_sh_valid", 64'(b_resp_valid), 64'd1);
        chk("ns_sh_err", 64'(b_resp_err), 64'd1);
        chk("ns_sh_rdata", 64'(b_resp_rdata), 64'd0);
        @(posedge clk); #1;
        chk("ns_ready", 64'(b_req_ready), 64'd1);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = 3'd2;
        b_req_addr = 32'h4;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        chk("ns_lw_busy", 64'(b_resp_valid), 64'd0);
        chk("ns_lw_addr", 64'(b_mem_addr), 64'h4);
        @(posedge clk); #1;
        chk("ns_lw_valid", 64'(b_resp_valid), 64'd1);
        chk("ns_lw_err", 64'(b_resp_err), 64'd0);
        chk("ns_lw_rdata", 64'(b_resp_rdata), 64'h12345678);
        @(posedge clk); #1;
        chk("ns_no_write", 64'(b_we_cnt), 64'd0);

        diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk("mem_image", 64'(diff), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
